// File: rtl/icache_dm.sv
// Direct-mapped, read-only instruction cache with one-word lines. Hits return in the
// same cycle; misses stall the fetch stage and fill the line over a req/ack handshake.
//
// state  | meaning
// -------+--------------------------------------------------------------
// S_IDLE | lookups active; a requested miss latches its address
// S_FILL | o_mem_req held at the latched address until i_mem_ack
module icache_dm #(
  parameter int IDX_W  = 4,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] i_addr_PC,
  input  logic              i_con_req,
  input  logic              i_con_flush,
  output logic [31:0]       o_data_Instr,
  output logic              o_con_stall,
  output logic              o_mem_req,
  output logic [ADDR_W-1:0] o_mem_addr,
  input  logic              i_mem_ack,
  input  logic [31:0]       i_mem_rdata
);

  localparam int LINES = 1 << IDX_W;
  localparam int TAG_W = ADDR_W - IDX_W - 2;

  typedef enum logic {S_IDLE, S_FILL} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [LINES-1:0]  r_valid;
  logic [TAG_W-1:0]  r_tag  [LINES];
  logic [31:0]       r_data [LINES];
  logic [ADDR_W-1:0] r_miss_addr;

  logic [IDX_W-1:0]  w_idx;
  logic [TAG_W-1:0]  w_tag;
  logic [IDX_W-1:0]  w_fill_idx;
  logic [TAG_W-1:0]  w_fill_tag;
  logic              w_hit;
  logic              w_launch;
  logic              w_fill_done;
  logic              w_unused_byte_sel;

  assign w_idx      = i_addr_PC[IDX_W+1:2];
  assign w_tag      = i_addr_PC[ADDR_W-1:IDX_W+2];
  assign w_fill_idx = r_miss_addr[IDX_W+1:2];
  assign w_fill_tag = r_miss_addr[ADDR_W-1:IDX_W+2];
  assign w_unused_byte_sel = ^i_addr_PC[1:0];

  // Lookups only count as hits in IDLE so a fill never races a same-cycle read.
  assign w_hit = i_con_req & r_valid[w_idx] & (r_tag[w_idx] == w_tag) & (r_state == S_IDLE);
  assign w_fill_done = (r_state == S_FILL) & i_mem_ack;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_miss_addr <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_launch)
        r_miss_addr <= {i_addr_PC[ADDR_W-1:2], 2'b00};
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_launch     = 1'b0;
    o_mem_req    = 1'b0;
    o_mem_addr   = '0;
    o_con_stall  = i_con_req & ~w_hit;
    o_data_Instr = w_hit ? r_data[w_idx] : 32'h0000_0000;
    case (r_state)
      S_IDLE: begin
        if (i_con_req && !w_hit) begin
          w_launch    = 1'b1;
          w_state_nxt = S_FILL;
        end
      end
      S_FILL: begin
        o_mem_req   = 1'b1;
        o_mem_addr  = r_miss_addr;
        o_con_stall = 1'b1;
        if (i_mem_ack)
          w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Flush has priority: a line filled in the flush cycle is written but left invalid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_valid <= '0;
    else if (i_con_flush)
      r_valid <= '0;
    else if (w_fill_done)
      r_valid[w_fill_idx] <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (w_fill_done) begin
      r_data[w_fill_idx] <= i_mem_rdata;
      r_tag[w_fill_idx]  <= w_fill_tag;
    end
  end

endmodule
